// File: rtl/ni_inject_arbiter.sv
// Packet-atomic, credit-gated round-robin arbiter sharing one NI injection link
// between NREQ FWFT send FIFOs; a grant is held from HEAD through TAIL.
module ni_inject_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned CREDITS   = 4,
    parameter int unsigned CW        = $clog2(CREDITS + 1),
    parameter logic [1:0]  FLIT_HEAD = 2'b10,
    parameter logic [1:0]  FLIT_TAIL = 2'b01
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o,
    input  logic                 credit_upd_i,
    output logic [NREQ-1:0]      grant_o,
    output logic                 busy_o,
    output logic [CW-1:0]        credit_o,
    output logic                 credit_err_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic            err_q, err_d;

    logic [DW-1:0]   flits [NREQ];
    logic [NREQ-1:0] eligible;
    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic            found;
    logic            xfer;
    logic            is_tail;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            flits[k]    = req_data_i[k*DW +: DW];
            eligible[k] = req_valid_i[k] && (flits[k][DW-1 -: 2] == FLIT_HEAD);
        end
    end

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) g_idx = PW'(k);
        end
    end

    // Round-robin search starting just after the last packet's owner.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = PW'((int'(ptr_q) + off) % NREQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        data_o      = flits[g_idx];
        valid_o     = (state_q == StLock) && req_valid_i[g_idx] && (credit_q != '0);
        req_ready_o = valid_o ? grant_q : '0;
        xfer        = valid_o;
        is_tail     = (data_o[DW-1 -: 2] == FLIT_TAIL);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d      = StLock;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                end
            end
            StLock: begin
                if (xfer && is_tail) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = g_idx;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A return with no transfer at full credit is an overflow: saturate and flag.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (xfer && !credit_upd_i) begin
            credit_d = credit_q - CW'(1);
        end else if (credit_upd_i && !xfer) begin
            if (credit_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            ptr_q    <= PW'(NREQ - 1);
            credit_q <= CW'(CREDITS);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign grant_o      = grant_q;
    assign busy_o       = (state_q == StLock);
    assign credit_o     = credit_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// Randomised and directed bench for ni_inject_arbiter against a packet/queue-level
// reference model of ownership, round-robin order and credit accounting.
module tb_ni_inject_arbiter;

    localparam int unsigned DW      = 32;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned CW      = $clog2(CREDITS + 1);
    localparam logic [1:0]  HEAD    = 2'b10;
    localparam logic [1:0]  BODY    = 2'b00;
    localparam logic [1:0]  TAIL    = 2'b01;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic [NREQ-1:0]    req_valid_i = '0;
    logic [NREQ*DW-1:0] req_data_i = '0;
    logic [NREQ-1:0]    req_ready_o;
    logic               valid_o;
    logic [DW-1:0]      data_o;
    logic               credit_upd_i = 1'b0;
    logic [NREQ-1:0]    grant_o;
    logic               busy_o;
    logic [CW-1:0]      credit_o;
    logic               credit_err_o;

    always #5 clk = ~clk;

    ni_inject_arbiter #(
        .DW        (DW),
        .NREQ      (NREQ),
        .CREDITS   (CREDITS),
        .CW        (CW),
        .FLIT_HEAD (HEAD),
        .FLIT_TAIL (TAIL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_upd_i (credit_upd_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .credit_o     (credit_o),
        .credit_err_o (credit_err_o)
    );

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: owner=-1 when no packet in flight.
    int m_owner;
    int m_ptr;
    int m_credit;
    bit m_err;

    int         log_src[$];
    int         log_cyc[$];
    logic [1:0] log_type[$];

    function automatic bit qempty(int k);
        return (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
    endfunction

    function automatic logic [DW-1:0] qfront(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(int k);
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush(int k, logic [DW-1:0] f);
        if (k == 0) q0.push_back(f);
        else q1.push_back(f);
    endtask

    task automatic push_pkt(int k, int len);
        logic [1:0] t;
        for (int i = 0; i < len; i++) begin
            t = (i == 0) ? HEAD : ((i == len - 1) ? TAIL : BODY);
            qpush(k, {t, 6'(k), 8'(i), 16'($urandom)});
        end
    endtask

    task automatic clear_log();
        log_src.delete();
        log_cyc.delete();
        log_type.delete();
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = NREQ - 1;
        m_credit = CREDITS;
        m_err    = 1'b0;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(int pct, bit upd, bit rst);
        for (int k = 0; k < NREQ; k++) begin
            bit g = ($urandom_range(99, 0) < pct);
            if (!qempty(k) && g) begin
                req_valid_i[k]            = 1'b1;
                req_data_i[k*DW +: DW]    = qfront(k);
            end else begin
                req_valid_i[k]            = 1'b0;
                req_data_i[k*DW +: DW]    = qempty(k) ? DW'($urandom) : qfront(k);
            end
        end
        credit_upd_i = upd;
        rst_i        = rst;
    endtask

    // Compare all outputs against the model, then advance the model across one edge.
    task automatic step();
        int              o;
        bit              xfer;
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   fl;
        #1;
        o    = m_owner;
        xfer = (o >= 0) && req_valid_i[o] && (m_credit > 0);
        eg   = '0;
        if (o >= 0) eg[o] = 1'b1;
        fl   = xfer ? qfront(o) : '0;
        chk("grant", 64'(grant_o), 64'(eg));
        chk("busy", 64'(busy_o), 64'(o >= 0));
        chk("valid", 64'(valid_o), 64'(xfer));
        chk("ready", 64'(req_ready_o), xfer ? 64'(eg) : 64'(0));
        chk("credit", 64'(credit_o), 64'(m_credit));
        chk("credit_err", 64'(credit_err_o), 64'(m_err));
        if (xfer) chk("data", 64'(data_o), 64'(fl));
        @(posedge clk);
        if (rst_i) begin
            model_reset();
            q0.delete();
            q1.delete();
        end else begin
            if (xfer && !credit_upd_i) m_credit--;
            else if (credit_upd_i && !xfer) begin
                if (m_credit == CREDITS) m_err = 1'b1;
                else m_credit++;
            end
            if (o < 0) begin
                for (int off = 1; off <= NREQ; off++) begin
                    int k = (m_ptr + off) % NREQ;
                    if (req_valid_i[k] && req_data_i[k*DW + DW - 1 -: 2] == HEAD) begin
                        m_owner = k;
                        break;
                    end
                end
            end else if (xfer) begin
                log_src.push_back(o);
                log_cyc.push_back(cyc);
                log_type.push_back(fl[DW-1 -: 2]);
                qpop(o);
                if (fl[DW-1 -: 2] == TAIL) begin
                    m_ptr   = o;
                    m_owner = -1;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // upd_mode: 0 never, 1 every cycle, 2 random but never beyond what is in flight.
    task automatic run(int n, int pct, int upd_mode);
        bit u;
        for (int i = 0; i < n; i++) begin
            case (upd_mode)
                0:       u = 1'b0;
                1:       u = 1'b1;
                default: u = (m_credit < CREDITS) && ($urandom_range(1, 0) == 1);
            endcase
            drive(pct, u, 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b1);
        step();
        clear_log();
    endtask

    initial begin
        int heads[$];
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Single requester, 4-flit packet, no credit returns.
        do_reset();
        chk("rst_credit", 64'(credit_o), 64'(4));
        chk("rst_grant", 64'(grant_o), 64'(0));
        push_pkt(0, 4);
        run(8, 100, 0);
        chk("t1_credit_drained", 64'(credit_o), 64'(0));
        chk("t1_grant_idle", 64'(grant_o), 64'(0));
        chk("t1_nflits", 64'(log_src.size()), 64'(4));
        if (log_cyc.size() == 4)
            chk("t1_back_to_back", 64'(log_cyc[3] - log_cyc[0]), 64'(3));

        // Two requesters, two packets each, credit returned every cycle.
        do_reset();
        push_pkt(0, 4); push_pkt(0, 4);
        push_pkt(1, 4); push_pkt(1, 4);
        run(30, 100, 1);
        chk("t2_nflits", 64'(log_src.size()), 64'(16));
        for (int i = 0; i < log_src.size(); i++) begin
            if (log_type[i] == HEAD) begin
                heads.push_back(log_src[i]);
                if (i > 0) chk("t2_one_bubble", 64'(log_cyc[i] - log_cyc[i-1]), 64'(2));
            end
        end
        chk("t2_npkts", 64'(heads.size()), 64'(4));
        for (int i = 0; i < 4 && i < heads.size(); i++)
            chk("t2_order", 64'(heads[i]), 64'(exp_order[i]));

        // Credit starvation on a 6-flit packet.
        do_reset();
        push_pkt(0, 6);
        run(8, 100, 0);
        chk("t3_stalled_count", 64'(log_src.size()), 64'(4));
        chk("t3_stalled_valid", 64'(valid_o), 64'(0));
        chk("t3_stalled_grant", 64'(grant_o), 64'(1));
        run(1, 100, 1);
        run(1, 100, 0);
        chk("t3_flit5_sent", 64'(log_src.size()), 64'(5));
        run(2, 100, 0);
        chk("t3_stall_again", 64'(log_src.size()), 64'(5));
        run(4, 100, 1);
        chk("t3_done", 64'(log_src.size()), 64'(6));

        // Transfer and credit return in the same cycle at credit 2.
        do_reset();
        push_pkt(0, 4);
        run(3, 100, 0);
        chk("t4_credit_before", 64'(credit_o), 64'(2));
        run(1, 100, 1);
        chk("t4_credit_held", 64'(credit_o), 64'(2));
        run(6, 100, 1);

        // Overflow is sticky until reset.
        do_reset();
        run(1, 100, 1);
        chk("t5_err_set", 64'(credit_err_o), 64'(1));
        chk("t5_saturated", 64'(credit_o), 64'(4));
        push_pkt(0, 3);
        run(8, 100, 0);
        chk("t5_err_sticky", 64'(credit_err_o), 64'(1));
        do_reset();
        chk("t5_err_cleared", 64'(credit_err_o), 64'(0));

        // Non-HEAD flit at requester 1 is never eligible in idle.
        do_reset();
        qpush(1, {BODY, 30'h155});
        push_pkt(0, 3);
        run(10, 100, 0);
        chk("t6_nflits", 64'(log_src.size()), 64'(3));
        if (log_src.size() > 0) chk("t6_owner", 64'(log_src[0]), 64'(0));
        chk("t6_ready1_low", 64'(req_ready_o[1]), 64'(0));

        // Reset after flit 2 of a 4-flit packet.
        do_reset();
        push_pkt(0, 4);
        run(3, 100, 0);
        chk("t7_two_sent", 64'(log_src.size()), 64'(2));
        drive(100, 1'b0, 1'b1);
        step();
        chk("t7_grant", 64'(grant_o), 64'(0));
        chk("t7_busy", 64'(busy_o), 64'(0));
        chk("t7_credit", 64'(credit_o), 64'(4));
        chk("t7_valid", 64'(valid_o), 64'(0));

        // Random traffic with bubbles and legal credit returns.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (((k == 0) ? q0.size() : q1.size()) < 8 && $urandom_range(3, 0) == 0)
                    push_pkt(k, int'($urandom_range(6, 2)));
            end
            run(1, 80, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
